// File: rtl/mul_float_arbiter_if.sv
// Handshake bundle between two multiplier clients, the arbiter and the shared mul_float_cal.
// master = arbiter view, slave = clients/multiplier view.
interface mul_float_arbiter_if;
  logic        iREQ0_REQ, oREQ0_BUSY, oREQ0_VALID, iREQ0_BUSY;
  logic [31:0] iREQ0_A, iREQ0_B, oREQ0_DATA;
  logic        iREQ1_REQ, oREQ1_BUSY, oREQ1_VALID, iREQ1_BUSY;
  logic [31:0] iREQ1_A, iREQ1_B, oREQ1_DATA;
  logic        oMUL_REQ, iMUL_BUSY, iMUL_VALID, oMUL_BUSY;
  logic [31:0] oMUL_A, oMUL_B, iMUL_DATA;
  logic        oERR;

  modport master (
    input  iREQ0_REQ, iREQ0_A, iREQ0_B, iREQ0_BUSY,
    input  iREQ1_REQ, iREQ1_A, iREQ1_B, iREQ1_BUSY,
    input  iMUL_BUSY, iMUL_VALID, iMUL_DATA,
    output oREQ0_BUSY, oREQ0_VALID, oREQ0_DATA,
    output oREQ1_BUSY, oREQ1_VALID, oREQ1_DATA,
    output oMUL_REQ, oMUL_A, oMUL_B, oMUL_BUSY, oERR
  );

  modport slave (
    output iREQ0_REQ, iREQ0_A, iREQ0_B, iREQ0_BUSY,
    output iREQ1_REQ, iREQ1_A, iREQ1_B, iREQ1_BUSY,
    output iMUL_BUSY, iMUL_VALID, iMUL_DATA,
    input  oREQ0_BUSY, oREQ0_VALID, oREQ0_DATA,
    input  oREQ1_BUSY, oREQ1_VALID, oREQ1_DATA,
    input  oMUL_REQ, oMUL_A, oMUL_B, oMUL_BUSY, oERR
  );
endinterface

// File: rtl/mul_float_arbiter.sv
// Round-robin sharing of one in-order multiplier between two clients; a tag FIFO
// remembers who issued each in-flight op so results can be steered back.
module mul_float_arbiter #(
  parameter int P_TAG_DEPTH   = 4,
  parameter int P_TAG_DEPTH_N = 2
)(
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  mul_float_arbiter_if.master bus
);
  localparam logic [P_TAG_DEPTH_N:0] LP_FULL = (P_TAG_DEPTH_N+1)'(P_TAG_DEPTH);

  logic                     rrLast, grant, issue, load, outBusy;
  logic                     fifoFull, fifoEmpty;
  logic [P_TAG_DEPTH-1:0]   tagMem;
  logic [P_TAG_DEPTH_N-1:0] wrPtr, rdPtr;
  logic [P_TAG_DEPTH_N:0]   count;
  logic                     outValid, outTag, err;
  logic [31:0]              outData;

  // Contention goes to whichever client did not issue last.
  always_comb begin
    grant = bus.iREQ1_REQ;
    if (bus.iREQ0_REQ & bus.iREQ1_REQ) grant = ~rrLast;
  end

  assign fifoFull   = (count == LP_FULL);
  assign fifoEmpty  = (count == '0);
  assign issue      = bus.oMUL_REQ & ~bus.iMUL_BUSY;
  assign outBusy    = outValid & (outTag ? bus.iREQ1_BUSY : bus.iREQ0_BUSY);
  // A result with nobody waiting for it is never popped or stored.
  assign load       = bus.iMUL_VALID & ~outBusy & ~fifoEmpty;

  assign bus.oMUL_REQ    = (bus.iREQ0_REQ | bus.iREQ1_REQ) & ~fifoFull;
  assign bus.oMUL_A      = grant ? bus.iREQ1_A : bus.iREQ0_A;
  assign bus.oMUL_B      = grant ? bus.iREQ1_B : bus.iREQ0_B;
  assign bus.oREQ0_BUSY  = grant  | bus.iMUL_BUSY | fifoFull;
  assign bus.oREQ1_BUSY  = ~grant | bus.iMUL_BUSY | fifoFull;
  assign bus.oMUL_BUSY   = outBusy;
  assign bus.oREQ0_VALID = outValid & ~outTag;
  assign bus.oREQ1_VALID = outValid &  outTag;
  assign bus.oREQ0_DATA  = outData;
  assign bus.oREQ1_DATA  = outData;
  assign bus.oERR        = err;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rrLast   <= 1'b1;
      tagMem   <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      outValid <= 1'b0;
      outTag   <= 1'b0;
      outData  <= '0;
      err      <= 1'b0;
    end else if (iRESET_SYNC) begin
      rrLast   <= 1'b1;
      tagMem   <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      outValid <= 1'b0;
      outTag   <= 1'b0;
      outData  <= '0;
      err      <= 1'b0;
    end else begin
      if (issue) begin
        rrLast        <= grant;
        tagMem[wrPtr] <= grant;
        wrPtr         <= wrPtr + 1'b1;
      end
      if (load) begin
        outValid <= 1'b1;
        outTag   <= tagMem[rdPtr];
        outData  <= bus.iMUL_DATA;
        rdPtr    <= rdPtr + 1'b1;
      end else if (outValid & ~outBusy) begin
        outValid <= 1'b0;
      end
      if (issue & ~load)      count <= count + 1'b1;
      else if (~issue & load) count <= count - 1'b1;
      if (bus.iMUL_VALID & fifoEmpty) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_float_arbiter.sv
// Directed bench: two scripted clients plus an in-order multiplier model with a
// fixed result table, checking routing, arbitration, backpressure and error handling.
module tb_mul_float_arbiter;
  logic iCLOCK = 1'b0, inRESET = 1'b0, iRESET_SYNC = 1'b0;
  mul_float_arbiter_if bus ();

  mul_float_arbiter #(.P_TAG_DEPTH(4), .P_TAG_DEPTH_N(2)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC), .bus(bus.master)
  );

  always #5 iCLOCK = ~iCLOCK;

  int nCmp = 0, nBad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Multiplier model: in-order, one cycle minimum latency, results from a table.
  function automatic logic [31:0] mulRes(input logic [31:0] a);
    case (a)
      32'h8220_0000: mulRes = 32'd100;
      32'h8548_0000: mulRes = 32'd10000;
      32'h887a_0000: mulRes = 32'd1000000;
      default:       mulRes = a ^ 32'hdead_beef;
    endcase
  endfunction

  logic [31:0] mq[$];
  logic [31:0] rx0[$], rx1[$];
  bit          grantLog[$];
  int          mqCnt = 0;
  logic [31:0] mqHead = '0;
  bit          mulHold = 0, spur = 0, mulBusy = 0;
  bit          lastFire = 0, fireNow, issNow, gNow, rsNow;
  logic [31:0] lastData = '0, aNow;

  assign bus.iMUL_VALID = ((mqCnt != 0) && !mulHold) || spur;
  assign bus.iMUL_DATA  = spur ? 32'h0000_0055 : mqHead;
  assign bus.iMUL_BUSY  = mulBusy;

  always @(posedge iCLOCK) begin
    // A result accepted at the previous edge must be visible now.
    if (lastFire) begin
      chk("resVal", {31'b0, bus.oREQ0_VALID | bus.oREQ1_VALID}, 32'd1);
      chk("resData", bus.oREQ0_DATA, lastData);
    end
    fireNow = bus.iMUL_VALID && !bus.oMUL_BUSY;
    issNow  = bus.oMUL_REQ && !bus.iMUL_BUSY;
    aNow    = bus.oMUL_A;
    gNow    = !(bus.iREQ0_REQ && !bus.oREQ0_BUSY);
    rsNow   = iRESET_SYNC || !inRESET;
    if (bus.oREQ0_VALID && !bus.iREQ0_BUSY && !rsNow) rx0.push_back(bus.oREQ0_DATA);
    if (bus.oREQ1_VALID && !bus.iREQ1_BUSY && !rsNow) rx1.push_back(bus.oREQ1_DATA);
    #1;
    lastFire = 0;
    if (rsNow) mq.delete();
    else begin
      if (fireNow && mq.size() != 0) begin
        lastFire = 1;
        lastData = mq.pop_front();
      end
      if (issNow) begin
        mq.push_back(mulRes(aNow));
        grantLog.push_back(gNow);
      end
    end
    mqCnt  = mq.size();
    mqHead = (mq.size() != 0) ? mq[0] : 32'h0;
  end

  task automatic waitRx(input bit which, input int n);
    for (int k = 0; k < 100 && (which ? rx1.size() : rx0.size()) < n; k++) @(negedge iCLOCK);
    chk(which ? "rx1Cnt" : "rx0Cnt", which ? rx1.size() : rx0.size(), n);
  endtask

  task automatic waitGrants(input int n);
    for (int k = 0; k < 100 && grantLog.size() < n; k++) @(negedge iCLOCK);
    chk("grantCnt", grantLog.size(), n);
  endtask

  task automatic issueOne(input bit who, input logic [31:0] a);
    if (who) begin bus.iREQ1_REQ = 1; bus.iREQ1_A = a; bus.iREQ1_B = a; end
    else     begin bus.iREQ0_REQ = 1; bus.iREQ0_A = a; bus.iREQ0_B = a; end
    @(negedge iCLOCK);
    bus.iREQ0_REQ = 0;
    bus.iREQ1_REQ = 0;
  endtask

  int base;
  initial begin
    bus.iREQ0_REQ = 0; bus.iREQ0_A = '0; bus.iREQ0_B = '0; bus.iREQ0_BUSY = 0;
    bus.iREQ1_REQ = 0; bus.iREQ1_A = '0; bus.iREQ1_B = '0; bus.iREQ1_BUSY = 0;
    repeat (2) @(negedge iCLOCK);
    // Reset state
    chk("rstMulReq", {31'b0, bus.oMUL_REQ}, 0);
    chk("rstBusy0", {31'b0, bus.oREQ0_BUSY}, 0);
    chk("rstBusy1", {31'b0, bus.oREQ1_BUSY}, 1);
    chk("rstValid", {30'b0, bus.oREQ1_VALID, bus.oREQ0_VALID}, 0);
    chk("rstErr", {31'b0, bus.oERR}, 0);
    chk("rstMulBusy", {31'b0, bus.oMUL_BUSY}, 0);
    mulBusy = 1; #1;
    chk("rstBusy0Mul", {31'b0, bus.oREQ0_BUSY}, 1);
    mulBusy = 0;
    inRESET = 1;
    @(negedge iCLOCK);

    // Single client
    bus.iREQ0_REQ = 1; bus.iREQ0_A = 32'h8220_0000; bus.iREQ0_B = 32'h8220_0000; #1;
    chk("s1MulReq", {31'b0, bus.oMUL_REQ}, 1);
    chk("s1MulA", bus.oMUL_A, 32'h8220_0000);
    @(negedge iCLOCK);
    bus.iREQ0_REQ = 0;
    waitRx(0, 1);
    chk("s1Data", rx0[0], 32'd100);
    repeat (3) @(negedge iCLOCK);
    chk("s1NoRx1", rx1.size(), 0);

    // Round-robin after a sync clear so client 0 leads
    iRESET_SYNC = 1; @(negedge iCLOCK); iRESET_SYNC = 0;
    grantLog.delete(); rx0.delete(); rx1.delete();
    bus.iREQ0_REQ = 1; bus.iREQ0_A = 32'h8548_0000; bus.iREQ0_B = 32'h8548_0000;
    bus.iREQ1_REQ = 1; bus.iREQ1_A = 32'h887a_0000; bus.iREQ1_B = 32'h887a_0000;
    waitGrants(4);
    bus.iREQ0_REQ = 0; bus.iREQ1_REQ = 0;
    for (int i = 0; i < 4; i++) chk("rrGrant", {31'b0, grantLog[i]}, i % 2);
    waitRx(0, 2); waitRx(1, 2);
    for (int i = 0; i < 2; i++) begin
      chk("rr0Data", rx0[i], 32'd10000);
      chk("rr1Data", rx1[i], 32'd1000000);
    end

    // FIFO full
    grantLog.delete(); rx0.delete(); mulHold = 1; base = 32'h1000_0000;
    bus.iREQ0_REQ = 1;
    for (int k = 0; k < 5; k++) begin
      bus.iREQ0_A = base + k; bus.iREQ0_B = base + k;
      if (k < 4) @(negedge iCLOCK);
    end
    chk("fullGrants", grantLog.size(), 4);
    chk("fullMulReq", {31'b0, bus.oMUL_REQ}, 0);
    chk("fullBusy0", {31'b0, bus.oREQ0_BUSY}, 1);
    mulHold = 0; #1;
    chk("fullPopMulReq", {31'b0, bus.oMUL_REQ}, 0);
    @(negedge iCLOCK);
    mulHold = 1;
    chk("fullNoSameCyc", grantLog.size(), 4);
    chk("fullReqAgain", {31'b0, bus.oMUL_REQ}, 1);
    chk("fullBusy0Free", {31'b0, bus.oREQ0_BUSY}, 0);
    @(negedge iCLOCK);
    bus.iREQ0_REQ = 0;
    chk("fullGrant5", grantLog.size(), 5);
    mulHold = 0;
    waitRx(0, 5);
    for (int k = 0; k < 5; k++) chk("fullData", rx0[k], mulRes(base + k));

    // Destination stall: client 1 result ahead of client 0
    rx0.delete(); rx1.delete(); mulHold = 1;
    issueOne(1, 32'h887a_0000);
    issueOne(0, 32'h8548_0000);
    bus.iREQ1_BUSY = 1; mulHold = 0;
    for (int k = 0; k < 20 && !bus.oREQ1_VALID; k++) @(negedge iCLOCK);
    for (int k = 0; k < 3; k++) begin
      chk("stV1", {31'b0, bus.oREQ1_VALID}, 1);
      chk("stMulBusy", {31'b0, bus.oMUL_BUSY}, 1);
      chk("stV0", {31'b0, bus.oREQ0_VALID}, 0);
      chk("stData", bus.oREQ1_DATA, 32'd1000000);
      @(negedge iCLOCK);
    end
    bus.iREQ1_BUSY = 0;
    waitRx(1, 1); waitRx(0, 1);
    chk("st1Data", rx1[0], 32'd1000000);
    chk("st0Data", rx0[0], 32'd10000);

    // Spurious result
    repeat (2) @(negedge iCLOCK);
    rx0.delete(); rx1.delete();
    spur = 1; @(negedge iCLOCK); spur = 0;
    chk("spErr", {31'b0, bus.oERR}, 1);
    repeat (3) @(negedge iCLOCK);
    chk("spErrSticky", {31'b0, bus.oERR}, 1);
    chk("spNoValid", {30'b0, bus.oREQ1_VALID, bus.oREQ0_VALID}, 0);
    chk("spNoRx", rx0.size() + rx1.size(), 0);

    // Sync reset with three ops in flight
    mulHold = 1; grantLog.delete();
    for (int k = 0; k < 3; k++) issueOne(0, 32'h2000_0000 + k);
    iRESET_SYNC = 1; @(negedge iCLOCK); iRESET_SYNC = 0;
    chk("rsErr", {31'b0, bus.oERR}, 0);
    chk("rsValid", {30'b0, bus.oREQ1_VALID, bus.oREQ0_VALID}, 0);
    chk("rsMulBusy", {31'b0, bus.oMUL_BUSY}, 0);
    grantLog.delete(); rx0.delete();
    bus.iREQ0_REQ = 1; bus.iREQ0_A = 32'h3000_0000; bus.iREQ0_B = 32'h3000_0000;
    bus.iREQ1_REQ = 1; bus.iREQ1_A = 32'h887a_0000; bus.iREQ1_B = 32'h887a_0000; #1;
    chk("rsBusy0", {31'b0, bus.oREQ0_BUSY}, 0);
    chk("rsBusy1", {31'b0, bus.oREQ1_BUSY}, 1);
    @(negedge iCLOCK);
    bus.iREQ1_REQ = 0;
    chk("rsGrant0", (grantLog.size() == 1) ? {31'b0, grantLog[0]} : 32'hffff_ffff, 0);
    // Three more must issue: the FIFO starts empty after the clear
    for (int k = 1; k < 4; k++) begin
      bus.iREQ0_A = 32'h3000_0000 + k; bus.iREQ0_B = 32'h3000_0000 + k;
      @(negedge iCLOCK);
    end
    bus.iREQ0_REQ = 0;
    chk("rsFourIssued", grantLog.size(), 4);
    mulHold = 0;
    waitRx(0, 4);
    for (int k = 0; k < 4; k++) chk("rsData", rx0[k], mulRes(32'h3000_0000 + k));
    chk("rsErrEnd", {31'b0, bus.oERR}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/mul_float_arbiter.md
# mul_float_arbiter

Two-requester arbiter that shares one `mul_float_cal` floating-point multiplier. It sits between two independent clients and the multiplier. It grants issue slots round-robin and records the issuing client of every in-flight operation in a tag FIFO. Because the multiplier returns results in issue order, each result is routed back to the client that issued it through a one-entry registered output stage.

## Interface
Parameters:
- `P_TAG_DEPTH`, default 4: maximum in-flight operations. Must be a power of two, at least 2.
- `P_TAG_DEPTH_N`, default 2: log2(`P_TAG_DEPTH`).

Ports:
- `iCLOCK` in 1: clock.
- `inRESET` in 1: reset, asynchronous, active-low.
- `iRESET_SYNC` in 1: synchronous clear, same effect as reset. The top level also drives it to the multiplier.
- `iREQ0_REQ` in 1: client 0 operand request.
- `oREQ0_BUSY` out 1: client 0 operand not accepted this cycle.
- `iREQ0_A` in 32, `iREQ0_B` in 32: client 0 operands.
- `oREQ0_VALID` out 1: client 0 result valid.
- `iREQ0_BUSY` in 1: client 0 result stall.
- `oREQ0_DATA` out 32: client 0 result.
- Client 1 ports are identical: `iREQ1_REQ`, `oREQ1_BUSY`, `iREQ1_A`, `iREQ1_B`, `oREQ1_VALID`, `iREQ1_BUSY`, `oREQ1_DATA`.
- `oMUL_REQ` out 1, `iMUL_BUSY` in 1, `oMUL_A` out 32, `oMUL_B` out 32: multiplier input side.
- `iMUL_VALID` in 1, `oMUL_BUSY` out 1, `iMUL_DATA` in 32: multiplier output side.
- `oERR` out 1: sticky protocol error.

## Operation
Handshake rules:
- Every channel transfers at a rising edge when REQ/VALID=1 and BUSY=0.
- A held request or result keeps its data stable until it transfers.

Arbitration (combinational from registered `rr_last`):
- `rr_last` resets to 1, so client 0 wins first.
- If only one client requests, it is granted.
- If both request, the client other than `rr_last` is granted.
- `rr_last` updates to the granted client only on an accepted issue. A grant that does not issue leaves the pointer unchanged.

Issue path:
- `oMUL_REQ = (iREQ0_REQ | iREQ1_REQ) & !fifo_full`.
- `oMUL_A` and `oMUL_B` are muxed from the granted client.
- For the granted client: `oREQn_BUSY = iMUL_BUSY | fifo_full`. The non-granted client sees `oREQn_BUSY = 1`.
- Issue is accepted when `oMUL_REQ & !iMUL_BUSY`. On acceptance the granted index is pushed into the tag FIFO.

Tag FIFO:
- `P_TAG_DEPTH` entries of 1 bit, with wrapping read/write pointers and a count of width `P_TAG_DEPTH_N`+1.
- `fifo_full` is count==`P_TAG_DEPTH`. When full, issue is blocked even if a pop happens in the same cycle.
- Push and pop in the same cycle are allowed when not full; count is unchanged in that case.

Result path:
- The output register holds `out_valid`, `out_tag` and `out_data`.
- `oMUL_BUSY = out_valid & iREQ[out_tag]_BUSY`.
- When `iMUL_VALID & !oMUL_BUSY`: load `out_data=iMUL_DATA`, `out_tag=`FIFO head, `out_valid=1`, and pop the FIFO.
- Otherwise, if the current output is accepted, clear `out_valid`.
- `oREQn_VALID = out_valid & (out_tag==n)`. Both `oREQn_DATA` outputs show `out_data`.

Error:
- `iMUL_VALID=1` while the FIFO is empty sets `oERR`.
- In that case no pop occurs and the result is dropped.
- `oERR` clears only on reset or `iRESET_SYNC`.

## Timing
- Reset values:
  - All outputs 0 except `oREQ0_BUSY` and `oREQ1_BUSY`, which equal `iMUL_BUSY` (client 0 granted, or blocked) and 1 respectively while no request is pending.
  - `rr_last`=1, FIFO empty, `out_valid`=0, `oERR`=0.
- Issue adds 0 cycles: `oMUL_REQ` follows `iREQn_REQ` combinationally.
- Result adds 1 cycle: a result accepted from the multiplier at edge T appears on `oREQn_VALID` after T.
- Back-to-back throughput is 1 result per cycle when the destination is not stalled.
- A stalled client stalls the multiplier output. In-order return means the other client waits too.
- `iRESET_SYNC` and async reset mid-operation:
  - FIFO, output register, `rr_last` and `oERR` clear at once.
  - In-flight multiplier results are discarded by the multiplier's own sync reset. Any that arrive anyway set `oERR`.

## Test plan
- **Single client:** client 0 issues `82200000 x 82200000`. Expect `oREQ0_VALID` with `oREQ0_DATA=32'd100` one cycle after the multiplier's `oDATA_VALID`, and `oREQ1_VALID` never asserted.
- **Round-robin:** both clients hold requests continuously, client 0 `85480000²` and client 1 `887a0000²`.
  - Grants alternate 0,1,0,1.
  - Client 0 receives 10000 and client 1 receives 1000000, each in issue order.
- **FIFO full:** hold `iMUL_VALID=0` and issue 4 requests. The 5th request sees BUSY=1 and `oMUL_REQ=0`. Release one result: the 5th issues the following cycle, not in the same cycle.
- **Destination stall:** client 1 holds `iREQ1_BUSY=1` with its result pending.
  - `oMUL_BUSY=1`.
  - A queued client 0 result is not delivered until client 1 accepts.
  - Data stays stable throughout the stall.
- **Spurious result:** pulse `iMUL_VALID` with the FIFO empty. `oERR` becomes 1 and stays 1; no client VALID is asserted.
- **Reset mid-flight:** with 3 operations in flight, pulse `iRESET_SYNC`. FIFO is empty, all VALID=0, `oERR`=0, and the next issue is granted to client 0.
